// File: rtl/nf_ram_arb.sv
// Round-robin arbiter time-sharing one single-port RAM between a fetch port (0)
// and a load/store port (1): latch winner, access RAM for one cycle, ack next cycle.
module nf_ram_arb #(
   parameter int unsigned addr_w = 32,
   parameter int unsigned data_w = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [addr_w-1:0] addr0,
   input  logic              we0,
   input  logic [data_w-1:0] wd0,
   output logic              ack0,
   output logic [data_w-1:0] rd0,
   input  logic              req1,
   input  logic [addr_w-1:0] addr1,
   input  logic              we1,
   input  logic [data_w-1:0] wd1,
   output logic              ack1,
   output logic [data_w-1:0] rd1,
   output logic [addr_w-1:0] ram_addr,
   output logic              ram_we,
   output logic [data_w-1:0] ram_wd,
   input  logic [data_w-1:0] ram_rd,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state, state_nx;
   logic              gnt, gnt_nx;
   logic              last, last_nx;
   logic [addr_w-1:0] a_addr, a_addr_nx;
   logic              a_we, a_we_nx;
   logic [data_w-1:0] a_wd, a_wd_nx;
   logic [data_w-1:0] rd_q, rd_q_nx;
   logic              win;

   // State and latched-request registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         gnt    <= 1'b0;
         last   <= 1'b1;
         a_addr <= '0;
         a_we   <= 1'b0;
         a_wd   <= '0;
         rd_q   <= '0;
      end else begin
         state  <= state_nx;
         gnt    <= gnt_nx;
         last   <= last_nx;
         a_addr <= a_addr_nx;
         a_we   <= a_we_nx;
         a_wd   <= a_wd_nx;
         rd_q   <= rd_q_nx;
      end
   end

   // On a tie the port that did not win last time gets the grant
   assign win = (req0 && req1) ? ~last : req1;

   // Next-state and latch updates
   always_comb begin
      state_nx  = state;
      gnt_nx    = gnt;
      last_nx   = last;
      a_addr_nx = a_addr;
      a_we_nx   = a_we;
      a_wd_nx   = a_wd;
      rd_q_nx   = rd_q;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               gnt_nx    = win;
               last_nx   = win;
               a_addr_nx = win ? addr1 : addr0;
               a_we_nx   = win ? we1 : we0;
               a_wd_nx   = win ? wd1 : wd0;
               state_nx  = ACCESS;
            end
         end
         ACCESS: begin
            if (!a_we) rd_q_nx = ram_rd;
            state_nx = RESP;
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs decoded from registered state; address/data held stable between accesses
   always_comb begin
      ram_addr = a_addr;
      ram_wd   = a_wd;
      ram_we   = 1'b0;
      ack0     = 1'b0;
      ack1     = 1'b0;
      rd0      = rd_q;
      rd1      = rd_q;
      busy     = (state != IDLE);
      if (state == ACCESS) ram_we = a_we;
      if (state == RESP) begin
         ack0 = ~gnt;
         ack1 = gnt;
      end
   end

endmodule

// File: tb/tb_nf_ram_arb.sv
// Directed bench for nf_ram_arb with a behavioural single-port RAM
// (combinational read, synchronous write) and a preload port.
module tb_nf_ram_arb;

   logic        clk, rst;
   logic        req0, we0, ack0, req1, we1, ack1;
   logic [31:0] addr0, wd0, rd0, addr1, wd1, rd1;
   logic [31:0] ram_addr, ram_wd, ram_rd;
   logic        ram_we, busy;

   logic        pl_we;
   logic [5:0]  pl_addr;
   logic [31:0] pl_wd;
   logic [31:0] mem [0:63];

   int tests = 0;
   int fails = 0;

   nf_ram_arb #(.addr_w(32), .data_w(32)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0), .we0(we0), .wd0(wd0), .ack0(ack0), .rd0(rd0),
      .req1(req1), .addr1(addr1), .we1(we1), .wd1(wd1), .ack1(ack1), .rd1(rd1),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wd(ram_wd), .ram_rd(ram_rd),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ram_rd = mem[ram_addr[5:0]];

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr[5:0]] <= ram_wd;
      else if (pl_we) mem[pl_addr] <= pl_wd;
   end

   function automatic logic [31:0] dat(input logic [31:0] a);
      return 32'hA000_0000 | a;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   logic g;

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
      pl_we = 1'b0; pl_addr = '0; pl_wd = '0;
      step();
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_acks",  32'({ack1, ack0}), 32'd0);
      chk("rst_we",    32'(ram_we), 32'd0);
      chk("rst_rd",    rd0, 32'd0);
      chk("rst_addr",  ram_addr, 32'd0);

      // Preload RAM while held in reset
      for (int a = 16; a < 24; a++) begin
         pl_we = 1'b1; pl_addr = 6'(a); pl_wd = dat(32'(a));
         step();
      end
      pl_we = 1'b1; pl_addr = 6'd5; pl_wd = 32'hDEAD_BEEF;
      step();
      pl_we = 1'b0;
      rst = 1'b0;

      // Read on port 0
      req0 = 1'b1; addr0 = 32'd5; we0 = 1'b0;
      step();
      chk("rd0_access_addr", ram_addr, 32'd5);
      chk("rd0_access_we",   32'(ram_we), 32'd0);
      chk("rd0_access_busy", 32'(busy), 32'd1);
      step();
      chk("rd0_ack",  32'({ack1, ack0}), 32'b01);
      chk("rd0_data", rd0, 32'hDEAD_BEEF);
      req0 = 1'b0;
      step();
      chk("rd0_idle", 32'({busy, ack1, ack0}), 32'd0);

      // Write then read on port 1
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'd9; wd1 = 32'h1234_5678;
      step();
      chk("wr1_we",   32'(ram_we), 32'd1);
      chk("wr1_addr", ram_addr, 32'd9);
      chk("wr1_wd",   ram_wd, 32'h1234_5678);
      step();
      chk("wr1_we_off", 32'(ram_we), 32'd0);
      chk("wr1_ack",    32'({ack1, ack0}), 32'b10);
      chk("wr1_rd_kept", rd1, 32'hDEAD_BEEF);
      req1 = 1'b0; we1 = 1'b0;
      step();
      req1 = 1'b1;
      step();
      chk("rd1_we", 32'(ram_we), 32'd0);
      step();
      chk("rd1_ack",  32'({ack1, ack0}), 32'b10);
      chk("rd1_data", rd1, 32'h1234_5678);
      req1 = 1'b0;
      step();

      // Continuous ties from reset alternate 0,1,0,1,...
      rst = 1'b1;
      step();
      rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 32'd16; addr1 = 32'd20;
      step();
      for (int k = 0; k < 6; k++) begin
         g = (k % 2) == 1;
         chk("tie_access_noack", 32'({ack1, ack0}), 32'd0);
         chk("tie_access_addr",  ram_addr, g ? addr1 : addr0);
         step();
         chk("tie_ack", 32'({ack1, ack0}), g ? 32'b10 : 32'b01);
         chk("tie_rd",  g ? rd1 : rd0, dat(g ? addr1 : addr0));
         if (g) addr1 = addr1 + 32'd1;
         else   addr0 = addr0 + 32'd1;
         if (k == 5) begin req0 = 1'b0; req1 = 1'b0; end
         step();
         chk("tie_idle", 32'({busy, ack1, ack0}), 32'd0);
         if (k < 5) step();
      end

      // Late arrival: port 1 rises during port 0's access
      req0 = 1'b1; addr0 = 32'd17;
      step();
      req1 = 1'b1; addr1 = 32'd21;
      chk("late_addr0", ram_addr, 32'd17);
      step();
      chk("late_ack0", 32'({ack1, ack0}), 32'b01);
      chk("late_rd0",  rd0, dat(32'd17));
      req0 = 1'b0;
      step();
      chk("late_idle", 32'({busy, ack1, ack0}), 32'd0);
      step();
      chk("late_addr1", ram_addr, 32'd21);
      step();
      chk("late_ack1", 32'({ack1, ack0}), 32'b10);
      chk("late_rd1",  rd1, dat(32'd21));
      req1 = 1'b0;
      step();

      // Reset during a read access discards it
      req0 = 1'b1; addr0 = 32'd18;
      step();
      chk("rstacc_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      chk("rstacc_after", 32'({busy, ack1, ack0}), 32'd0);
      rst = 1'b0; req0 = 1'b0;
      step();
      chk("rstacc_noack", 32'({busy, ack1, ack0}), 32'd0);

      // Reset coinciding with a write request: no write, no ack
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wd0 = 32'h5555_5555; rst = 1'b1;
      step();
      chk("rstwr_after", 32'({ram_we, busy, ack1, ack0}), 32'd0);
      rst = 1'b0; req0 = 1'b0; we0 = 1'b0;
      step();
      chk("rstwr_we", 32'({ram_we, ack1, ack0}), 32'd0);
      step();
      chk("rstwr_mem", mem[5], 32'hDEAD_BEEF);

      // Back-to-back reads from port 0 alone, one every 3 cycles
      req0 = 1'b1; addr0 = 32'd16;
      step();
      for (int k = 0; k < 4; k++) begin
         chk("b2b_addr", ram_addr, addr0);
         step();
         chk("b2b_ack", 32'({ack1, ack0}), 32'b01);
         chk("b2b_rd",  rd0, dat(addr0));
         addr0 = addr0 + 32'd1;
         if (k == 3) req0 = 1'b0;
         step();
         chk("b2b_idle", 32'({busy, ack1, ack0}), 32'd0);
         if (k < 3) step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
